clk_div_meter: RTL and testbench
================================

Name: clk_div_meter

Overview:
- Receive end of the clock divider: takes an asynchronous divided/slow clock and measures its period and high time in system-clock cycles.
- Recovers the effective divide setting, e.g. a divider toggling every 30 clk gives period 60 and high time 30.
- Used for on-board self-check of divider outputs and for measuring external slow signals (buttons excluded, no debounce).
- Publishes one measurement per input cycle with a valid strobe, and flags a stalled input via a timeout.

Parameters:
- CNT_W, 27, width of the cycle counters and of the measurement outputs.
- TIMEOUT, 27'd100_000_000, clk cycles without an expected edge before the stall flag is set. Must be < 2^CNT_W, so the counters never wrap.
- SYNC_STAGES, 2, flip-flop stages in the input synchronizer (>=2).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- en  in  1  measurement enable.
- sig_in  in  1  asynchronous input clock/signal to be measured.
- period  out  CNT_W  clk cycles between consecutive synchronized rising edges.
- high_time  out  CNT_W  clk cycles sig_in spent high within that period.
- valid  out  1  one-cycle pulse when period/high_time update.
- stalled  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, async): state=IDLE; counters, period, high_time, valid, stalled and synchronizer flops all 0.
- Input path: SYNC_STAGES-flop synchronizer, then a registered copy s_d.
  - rise = s & ~s_d; fall = ~s & s_d.
  - Edge detection latency is SYNC_STAGES+1 clk. It is the same for both edges, so it cancels in all measurements.
- cnt: cleared to 0 in the cycle rise is seen (when entering or re-entering HIGH); +1 every other cycle while in HIGH or LOW.
- States and transitions:
  - IDLE: en=1 -> WAIT_RISE. Outputs hold.
  - WAIT_RISE: discards any partial cycle. rise -> HIGH, cnt<=0.
  - HIGH: fall -> LOW, hi_cnt<=cnt+1.
  - LOW: rise -> publish and go to HIGH with cnt<=0. Publish means period<=cnt+1, high_time<=hi_cnt, valid<=1, stalled<=0. Measurement is continuous: each rise both closes one cycle and opens the next.
- Timeout: in WAIT_RISE, HIGH or LOW, if cnt reaches TIMEOUT before the next expected edge, then stalled<=1 and state -> WAIT_RISE. period/high_time hold, no valid. WAIT_RISE counts toward timeout from its entry.
- en=0 in any state: next state IDLE, measurement in progress discarded, valid=0, period/high_time/stalled hold.
- valid is high for exactly one cycle per published measurement and never on two consecutive cycles. The minimum published period is 2.
- rise and fall cannot occur in the same cycle (single-bit sync path).
- A rise seen in HIGH or a fall seen in LOW/WAIT_RISE is ignored.
- Reset asserted mid-measurement: immediate return to the reset values above. The first valid after release needs one full input cycle after the first rise.

Decomposition:
- Shared package/header clk_meas_pkg holds:
  - state encodings IDLE=2'd0, WAIT_RISE=2'd1, HIGH=2'd2, LOW=2'd3;
  - default CNT_W and TIMEOUT constants.
- One sub-module, sync_edge_det (params SYNC_STAGES):
  - inputs clk, rst, async_in;
  - outputs sync_out, rise, fall;
  - also reused by the debounce/keypad blocks.
- FSM, counters and output registers stay in clk_div_meter.

Test Plan:
1. sig_in driven by clock_div with div=30, en=1 -> first valid after the second synchronized rise. Then period=60, high_time=30 on every valid, valid spaced exactly 60 clk apart, stalled=0.
2. Bench-generated sig_in, high 10 clk / low 25 clk -> period=35, high_time=10; change to high 3 / low 2 -> next full cycle reports period=5, high_time=3.
3. TIMEOUT=200 (bench override), one full 40-clk cycle published, then sig_in held low -> stalled=1 when cnt hits 200, no valid, period=40 held. Resume 40-clk cycles -> stalled=0 on the next valid.
4. en dropped mid-HIGH for 5 clk, then re-raised -> no valid for the aborted cycle; the first new valid comes one full cycle after the first rise following re-enable, with correct period.
5. rst pulled low asynchronously between clk edges mid-LOW -> period, high_time, valid, stalled read 0 before the next clk edge. After release with div=30, the first valid again reports 60/30.
6. Minimum input, high 2 / low 2 clk -> period=4, high_time=2, valid every 4 clk.

Source files
------------

// File: rtl/clk_meas_pkg.sv
// Shared definitions for the slow-clock period/high-time meter.
package clk_meas_pkg;

  localparam int CNT_W_DEF = 27;
  localparam logic [26:0] TIMEOUT_DEF = 27'd100_000_000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } meter_state_e;

endpackage

// File: rtl/clk_div_meter_if.sv
// Bundle of meter controls and measurement results, plus debug visibility.
interface clk_div_meter_if
  import clk_meas_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();
  // Handshake: valid is a one-cycle strobe with no ready; period/high_time are
  // stable from the valid cycle until the next valid, so a consumer may latch
  // them on valid or read them at any later time.
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             stalled;
  meter_state_e     state;
  logic             sig_sync;

  modport master (
    input  en, sig_in,
    output period, high_time, valid, stalled, state, sig_sync
  );

  modport slave (
    output en, sig_in,
    input  period, high_time, valid, stalled, state, sig_sync
  );
endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer with registered-copy edge detection.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~s_d;
  assign fall     = ~sync_out & s_d;

endmodule

// File: rtl/clk_div_meter.sv
// Measures period and high time of an asynchronous slow signal in clk cycles,
// publishing one result per input cycle and flagging a stalled input.
module clk_div_meter
  import clk_meas_pkg::*;
#(
  parameter int               CNT_W       = CNT_W_DEF,
  parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(TIMEOUT_DEF),
  parameter int               SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  clk_div_meter_if.master bus
);

  meter_state_e     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] hi_cnt, hi_cnt_nxt;
  logic [CNT_W-1:0] period, period_nxt;
  logic [CNT_W-1:0] high_time, high_time_nxt;
  logic             valid, valid_nxt;
  logic             stalled, stalled_nxt;
  logic             sig_sync, rise, fall;
  logic             timed_out;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.sig_in),
    .sync_out (sig_sync),
    .rise     (rise),
    .fall     (fall)
  );

  assign timed_out = (cnt == TIMEOUT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_cnt    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      stalled   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hi_cnt    <= hi_cnt_nxt;
      period    <= period_nxt;
      high_time <= high_time_nxt;
      valid     <= valid_nxt;
      stalled   <= stalled_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt + 1'b1;
    hi_cnt_nxt    = hi_cnt;
    period_nxt    = period;
    high_time_nxt = high_time;
    valid_nxt     = 1'b0;
    stalled_nxt   = stalled;

    if (!bus.en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = WAIT_RISE;
          cnt_nxt   = '0;
        end
        WAIT_RISE: begin
          if (rise) begin
            state_nxt = HIGH;
            cnt_nxt   = '0;
          end else if (timed_out) begin
            stalled_nxt = 1'b1;
            cnt_nxt     = '0;
          end
        end
        HIGH: begin
          if (fall) begin
            state_nxt  = LOW;
            hi_cnt_nxt = cnt + 1'b1;
          end else if (timed_out) begin
            state_nxt   = WAIT_RISE;
            stalled_nxt = 1'b1;
            cnt_nxt     = '0;
          end
        end
        LOW: begin
          // A rise closes the current cycle and opens the next one.
          if (rise) begin
            state_nxt     = HIGH;
            cnt_nxt       = '0;
            period_nxt    = cnt + 1'b1;
            high_time_nxt = hi_cnt;
            valid_nxt     = 1'b1;
            stalled_nxt   = 1'b0;
          end else if (timed_out) begin
            state_nxt   = WAIT_RISE;
            stalled_nxt = 1'b1;
            cnt_nxt     = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.period    = period;
  assign bus.high_time = high_time;
  assign bus.valid     = valid;
  assign bus.stalled   = stalled;
  assign bus.state     = state;
  assign bus.sig_sync  = sig_sync;

endmodule

// File: tb/tb_clk_div_meter.sv
// Directed bench for clk_div_meter: steady-rate vectors plus timeout, enable and reset sequences.
module tb_clk_div_meter;
  import clk_meas_pkg::*;

  localparam int W = 27;

  typedef struct {
    int hi;
    int lo;
    int n;
    int exp_p;
    int exp_h;
  } vec_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;
  int   hi_len;
  int   lo_len;
  bit   gen_on;
  bit   prev_valid;
  int   consec_valid;

  clk_div_meter_if #(.CNT_W(W)) bus ();

  clk_div_meter #(
    .CNT_W       (W),
    .TIMEOUT     (27'd200),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Slow-signal generator: hi_len cycles high, lo_len low; stops low when gen_on drops.
  initial begin
    int ph;
    ph = 0;
    bus.sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ph == 0 && !gen_on) begin
        bus.sig_in = 1'b0;
      end else begin
        bus.sig_in = (ph < hi_len);
        ph = ph + 1;
        if (ph >= hi_len + lo_len) ph = 0;
      end
    end
  end

  // valid must never be high on two consecutive cycles
  initial begin
    prev_valid   = 1'b0;
    consec_valid = 0;
    forever begin
      @(negedge clk);
      if (bus.valid && prev_valid) consec_valid = consec_valid + 1;
      prev_valid = bus.valid;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    checks = checks + 1;
    if (act < lo || act > hi) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_valid(input int budget, output bit got, output logic [W-1:0] p,
                            output logic [W-1:0] h, output bit st, output int at);
    got = 1'b0;
    p   = '0;
    h   = '0;
    st  = 1'b0;
    at  = cyc;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.valid) begin
        got = 1'b1;
        p   = bus.period;
        h   = bus.high_time;
        st  = bus.stalled;
        at  = cyc;
        break;
      end
    end
  endtask

  vec_t       vecs[5];
  bit         got;
  bit         st;
  logic [W-1:0] p, h;
  int         at, last_at, t0;

  initial begin
    vecs[0] = '{hi: 30, lo: 30, n: 3, exp_p: 60, exp_h: 30};
    vecs[1] = '{hi: 10, lo: 25, n: 3, exp_p: 35, exp_h: 10};
    vecs[2] = '{hi: 3,  lo: 2,  n: 4, exp_p: 5,  exp_h: 3};
    vecs[3] = '{hi: 2,  lo: 2,  n: 4, exp_p: 4,  exp_h: 2};
    vecs[4] = '{hi: 7,  lo: 13, n: 3, exp_p: 20, exp_h: 7};

    checks   = 0;
    failures = 0;
    gen_on   = 1'b0;
    hi_len   = 30;
    lo_len   = 30;
    rst      = 1'b0;
    bus.en   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_period", bus.period, 0);
    check("rst_high_time", bus.high_time, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_stalled", bus.stalled, 0);
    check("rst_state", bus.state, IDLE);

    @(posedge clk); #1;
    rst    = 1'b1;
    bus.en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    t0     = cyc;
    gen_on = 1'b1;

    // First valid needs one full input cycle after the first synchronized rise
    wait_valid(200, got, p, h, st, at);
    check("first_valid_seen", got, 1);
    check_range("first_valid_latency", at - t0, 60, 68);
    check("first_period", p, 60);
    check("first_high_time", h, 30);

    // Steady-rate vectors
    foreach (vecs[v]) begin
      hi_len = vecs[v].hi;
      lo_len = vecs[v].lo;
      for (int k = 0; k < 2; k++) wait_valid(400, got, p, h, st, at);
      check($sformatf("v%0d_settle_seen", v), got, 1);
      last_at = at;
      for (int k = 0; k < vecs[v].n; k++) begin
        wait_valid(400, got, p, h, st, at);
        check($sformatf("v%0d_seen", v), got, 1);
        check($sformatf("v%0d_period", v), p, vecs[v].exp_p);
        check($sformatf("v%0d_high_time", v), h, vecs[v].exp_h);
        check($sformatf("v%0d_spacing", v), at - last_at, vecs[v].exp_p);
        check($sformatf("v%0d_stalled", v), st, 0);
        last_at = at;
      end
    end

    // Timeout: publish one 40-clk cycle, then hold the input low
    hi_len = 20;
    lo_len = 20;
    for (int k = 0; k < 3; k++) wait_valid(400, got, p, h, st, at);
    check("to_pre_period", p, 40);
    gen_on = 1'b0;
    last_at = at;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.valid) got = 1'b1;
      if (bus.stalled) break;
    end
    check("to_stalled", bus.stalled, 1);
    check_range("to_stall_delay", cyc - last_at, 200, 202);
    check("to_no_valid", got, 0);
    check("to_period_hold", bus.period, 40);
    check("to_high_hold", bus.high_time, 20);
    check("to_state", bus.state, WAIT_RISE);
    repeat (20) @(negedge clk);
    check("to_still_stalled", bus.stalled, 1);
    gen_on = 1'b1;
    wait_valid(200, got, p, h, st, at);
    check("to_resume_seen", got, 1);
    check("to_resume_period", p, 40);
    check("to_resume_stalled", st, 0);

    // Enable dropped mid-HIGH: aborted cycle must not publish
    hi_len = 30;
    lo_len = 30;
    for (int k = 0; k < 3; k++) wait_valid(400, got, p, h, st, at);
    repeat (10) @(posedge clk);
    #1;
    check("en_in_high", bus.state, HIGH);
    bus.en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("en_idle", bus.state, IDLE);
    bus.en = 1'b1;
    t0 = cyc;
    wait_valid(300, got, p, h, st, at);
    check("en_resume_seen", got, 1);
    check_range("en_resume_latency", at - t0, 100, 108);
    check("en_resume_period", p, 60);
    check("en_resume_high_time", h, 30);

    // Asynchronous reset mid-LOW
    repeat (40) @(posedge clk);
    #1;
    check("rst_mid_in_low", bus.state, LOW);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_period", bus.period, 0);
    check("rst_async_high_time", bus.high_time, 0);
    check("rst_async_valid", bus.valid, 0);
    check("rst_async_stalled", bus.stalled, 0);
    check("rst_async_state", bus.state, IDLE);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    t0 = cyc;
    wait_valid(300, got, p, h, st, at);
    check("rst_resume_seen", got, 1);
    check_range("rst_resume_latency", at - t0, 60, 125);
    check("rst_resume_period", p, 60);
    check("rst_resume_high_time", h, 30);

    check("no_consecutive_valid", consec_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
